gesture_servo_ctrl: RTL and testbench
=====================================

# gesture_servo_ctrl

Parametrised gesture-to-servo controller: maps a gesture code to per-channel pulse widths via a runtime-writable gesture table, slews each channel toward its target once per servo frame, and generates NUM_CH servo PWM outputs from one shared frame counter. Sits between the gesture classifier and the finger servos of the robot hand.

## Interface
- NUM_CH, 5: servo channel count (1..16)
- GW, 8: gesture code width
- TBL_DEPTH, 16: gesture table entries; codes >= TBL_DEPTH are ignored
- CLK_HZ, 50_000_000: clock frequency; integer multiple of 1_000_000
- FRAME_US, 20000: PWM frame period in µs
- MIN_US / MAX_US / NEUTRAL_US, 1000 / 2000 / 1500: width clamp limits and reset width; MIN_US <= NEUTRAL_US <= MAX_US < FRAME_US
- STEP_US, 10: maximum width change per channel per frame (slew build only)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- gesture  in  GW  gesture code; 0 = hold current targets
- gesture_valid  in  1  single-cycle strobe qualifying gesture
- tbl_we  in  1  table write enable
- tbl_addr  in  $clog2(TBL_DEPTH)  gesture entry to write
- tbl_ch  in  $clog2(NUM_CH)  channel within entry
- tbl_data  in  16  width in µs
- pwm_out  out  NUM_CH  servo PWM, one bit per channel
- frame_start  out  1  one-cycle pulse at each frame wrap
- busy  out  1  high while any channel's current width != target

## Operation
- Prescaler counts 0..CLK_HZ/1e6-1; tick asserted on wrap (one pulse per µs).
- us_cnt counts 0..FRAME_US-1 on tick; on tick with us_cnt==FRAME_US-1: us_cnt <= 0, frame_start <= 1 for that cycle only.
- Per channel: pwm_out[i] <= (us_cnt < cur[i]), registered.
- Table: TBL_DEPTH x NUM_CH registers, 16 bit; tbl_data clamped to [MIN_US, MAX_US] on write; tbl_ch >= NUM_CH ignores the write.
- Gesture accept: gesture_valid && gesture!=0 && gesture<TBL_DEPTH -> target[i] <= table[gesture][i] for all i. Otherwise targets hold.
- Current-width update occurs only on the frame-wrap edge, never mid-frame (no pulse glitches).
- busy = OR over i of (cur[i] != target[i]), combinational from registers.
- Arithmetic: diff = target - cur in 17-bit signed; widths always stay in [MIN_US, MAX_US].

## Timing
- Reset (sync): prescaler, us_cnt = 0; table entries, target, cur = NEUTRAL_US; pwm_out = 0, frame_start = 0, busy = 0.
- First cycle after reset: pwm_out goes high on the next edge (us_cnt=0 < cur).
- gesture_valid -> target updated 1 cycle later; cur changes at the next frame wrap; new width appears in the frame starting there.
- Table write and gesture lookup of the same entry in the same cycle: lookup returns old data; new data visible next cycle.
- gesture_valid coinciding with frame wrap: cur update uses old target; new target takes effect at the following wrap.
- Reset asserted mid-frame: all state returns to reset values on that edge; targets and table contents lost.

## Configuration
- GESTURE_SERVO_SLEW_EN defined: at each wrap cur[i] moves toward target[i] by min(STEP_US, |diff|).
- Undefined: at each wrap cur[i] <= target[i] (single-frame jump); STEP_US unused.

## Structure
- Package gesture_servo_pkg: default parameter constants (MIN/MAX/NEUTRAL widths, frame length), width_t typedef (16-bit), clamp_us function.
- Sub-module servo_channel: holds target/cur for one channel, slew step, PWM compare; instantiated NUM_CH times via generate. Top holds prescaler, frame counter, table.

## Test plan
Benches use CLK_HZ=1_000_000, FRAME_US=2500, STEP_US=100.
- Reset release -> every pwm_out high exactly 1500 cycles per 2500-cycle frame; busy=0; frame_start every 2500 cycles.
- Write table[3] = {1000,1200,1500,1800,2000}, strobe gesture=3 -> busy=1 next cycle; slew build: ch0 width 1400,1300,...,1000 over 5 frames, ch4 reaches 2000 after 5 frames, then busy=0; non-slew build: all widths final after 1 wrap.
- Write tbl_data=500 and 2600 -> stored and driven as 1000 and 2000.
- gesture=0 or gesture=20 with gesture_valid -> targets unchanged, busy stays 0.
- gesture_valid on the frame_start cycle -> cur unchanged at that wrap; change begins at the next wrap.
- Reset mid-slew (frame 2 of 5) -> next cycle all cur/target = 1500, pwm_out=0, table back to 1500.

Source files
------------

// File: rtl/gesture_servo_pkg.sv
// gesture_servo_pkg
// Shared defaults, the 16-bit pulse-width type and the width clamp helper
// used by gesture_servo_ctrl and servo_channel.
package gesture_servo_pkg;

  localparam int unsigned DEF_CLK_HZ     = 50_000_000;
  localparam int unsigned DEF_FRAME_US   = 20000;
  localparam int unsigned DEF_MIN_US     = 1000;
  localparam int unsigned DEF_MAX_US     = 2000;
  localparam int unsigned DEF_NEUTRAL_US = 1500;
  localparam int unsigned DEF_STEP_US    = 10;

  typedef logic [15:0] width_t;

  function automatic width_t clamp_us(input width_t v, input width_t lo, input width_t hi);
    width_t r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// servo_channel
// One servo channel: target width register, current width register that only
// moves on frame wrap, and the registered PWM compare.
// Build option: GESTURE_SERVO_SLEW_EN limits each wrap's move to STEP_US;
// without it cur jumps straight to target at the wrap.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load            accept load_width as the new target
//   load_width      width from the gesture table
//   wrap            frame-wrap strobe (cur update edge)
//   us_cnt          shared microsecond position within the frame
//   pwm             registered PWM output
//   busy            cur != target
module servo_channel
  import gesture_servo_pkg::*;
#(
  parameter int unsigned NEUTRAL_US = DEF_NEUTRAL_US,
  parameter int unsigned STEP_US    = DEF_STEP_US
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  width_t load_width,
  input  logic   wrap,
  input  width_t us_cnt,
  output logic   pwm,
  output logic   busy
);

`ifdef GESTURE_SERVO_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  // Without slew the step limit exceeds any possible diff, so the slew path
  // always lands on target in a single wrap.
  localparam int unsigned      STEP_EFF = SLEW_EN ? STEP_US : 32'd65535;
  localparam logic signed [16:0] STEP_S = 17'(STEP_EFF);
  localparam width_t           STEP_W   = width_t'(STEP_EFF);

  width_t             target;
  width_t             cur;
  width_t             cur_next;
  logic signed [16:0] diff;

  always_comb begin
    diff     = $signed({1'b0, target}) - $signed({1'b0, cur});
    cur_next = target;
    if (diff > STEP_S)       cur_next = cur + STEP_W;
    else if (diff < -STEP_S) cur_next = cur - STEP_W;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      target <= width_t'(NEUTRAL_US);
      cur    <= width_t'(NEUTRAL_US);
      pwm    <= 1'b0;
    end else begin
      if (load) target <= load_width;
      if (wrap) cur <= cur_next;
      pwm <= (us_cnt < cur);
    end
  end

  assign busy = (cur != target);

endmodule

// File: rtl/gesture_servo_ctrl.sv
// gesture_servo_ctrl
// Gesture-to-servo controller: runtime-writable gesture table maps a gesture
// code to per-channel pulse widths; each channel moves toward its target only
// at frame wrap and drives a servo PWM from one shared frame counter.
// Build option: GESTURE_SERVO_SLEW_EN (per-frame slew limit of STEP_US).
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   gesture/gesture_valid  gesture code and its one-cycle strobe (0 = hold)
//   tbl_we/tbl_addr/tbl_ch/tbl_data  gesture table write port (width in us)
//   pwm_out                servo PWM, one bit per channel
//   frame_start            one-cycle pulse after each frame wrap
//   busy                   some channel has not reached its target
module gesture_servo_ctrl
  import gesture_servo_pkg::*;
#(
  parameter int unsigned NUM_CH     = 5,
  parameter int unsigned GW         = 8,
  parameter int unsigned TBL_DEPTH  = 16,
  parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
  parameter int unsigned FRAME_US   = DEF_FRAME_US,
  parameter int unsigned MIN_US     = DEF_MIN_US,
  parameter int unsigned MAX_US     = DEF_MAX_US,
  parameter int unsigned NEUTRAL_US = DEF_NEUTRAL_US,
  parameter int unsigned STEP_US    = DEF_STEP_US,
  localparam int unsigned AW = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1,
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GW-1:0]     gesture,
  input  logic              gesture_valid,
  input  logic              tbl_we,
  input  logic [AW-1:0]     tbl_addr,
  input  logic [CW-1:0]     tbl_ch,
  input  logic [15:0]       tbl_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic              busy
);

  localparam int unsigned PRE_DIV = CLK_HZ / 1_000_000;
  localparam int unsigned PW      = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int unsigned UW      = $clog2(FRAME_US);

  logic [PW-1:0]     pre_cnt;
  logic [UW-1:0]     us_cnt;
  logic              tick;
  logic              wrap;
  logic              accept;
  logic [AW-1:0]     g_idx;
  width_t            us_w;
  width_t            tbl [TBL_DEPTH][NUM_CH];
  logic [NUM_CH-1:0] ch_busy;

  assign tick   = (pre_cnt == PW'(PRE_DIV - 1));
  assign wrap   = tick && (us_cnt == UW'(FRAME_US - 1));
  assign accept = gesture_valid && (gesture != '0) && (32'(gesture) < TBL_DEPTH);
  assign g_idx  = AW'(gesture);
  assign us_w   = width_t'(us_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt     <= '0;
      us_cnt      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) begin
        pre_cnt <= '0;
        us_cnt  <= wrap ? '0 : us_cnt + UW'(1);
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

  // Lookup reads the registered table, so a same-cycle write is seen only
  // by later gestures.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned a = 0; a < TBL_DEPTH; a++) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          tbl[AW'(a)][CW'(c)] <= width_t'(NEUTRAL_US);
        end
      end
    end else if (tbl_we && (32'(tbl_addr) < TBL_DEPTH) && (32'(tbl_ch) < NUM_CH)) begin
      tbl[tbl_addr][tbl_ch] <= clamp_us(tbl_data, width_t'(MIN_US), width_t'(MAX_US));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_channel #(
      .NEUTRAL_US(NEUTRAL_US),
      .STEP_US   (STEP_US)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .load      (accept),
      .load_width(tbl[g_idx][i]),
      .wrap      (wrap),
      .us_cnt    (us_w),
      .pwm       (pwm_out[i]),
      .busy      (ch_busy[i])
    );
  end

  assign busy = |ch_busy;

endmodule

// File: tb/tb_gesture_servo_ctrl.sv
// tb_gesture_servo_ctrl
// Scoreboard bench for gesture_servo_ctrl at CLK_HZ=1 MHz, FRAME_US=2500,
// STEP_US=100. Expected per-frame pulse widths come from a small reference
// model and are queued before each frame is measured.
module tb_gesture_servo_ctrl;

  localparam int NUM_CH = 5;
  localparam int FRAME  = 2500;
`ifdef GESTURE_SERVO_SLEW_EN
  localparam int STEP = 100;
`else
  localparam int STEP = 1_000_000;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        gesture;
  logic              gesture_valid;
  logic              tbl_we;
  logic [3:0]        tbl_addr;
  logic [2:0]        tbl_ch;
  logic [15:0]       tbl_data;
  logic [NUM_CH-1:0] pwm_out;
  logic              frame_start;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int model_cur[NUM_CH];
  int model_tgt[NUM_CH];
  int model_tbl[16][NUM_CH];

  gesture_servo_ctrl #(
    .NUM_CH(5), .GW(8), .TBL_DEPTH(16), .CLK_HZ(1_000_000), .FRAME_US(2500),
    .MIN_US(1000), .MAX_US(2000), .NEUTRAL_US(1500), .STEP_US(100)
  ) dut (
    .clk(clk), .reset(reset), .gesture(gesture), .gesture_valid(gesture_valid),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_ch(tbl_ch), .tbl_data(tbl_data),
    .pwm_out(pwm_out), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      model_cur[i] = 1500;
      model_tgt[i] = 1500;
      for (int a = 0; a < 16; a++) model_tbl[a][i] = 1500;
    end
  endtask

  task automatic model_write(input int a, input int c, input int d);
    if (c < NUM_CH) model_tbl[a][c] = (d < 1000) ? 1000 : (d > 2000) ? 2000 : d;
  endtask

  task automatic model_gesture(input int g);
    if (g != 0 && g < 16)
      for (int i = 0; i < NUM_CH; i++) model_tgt[i] = model_tbl[g][i];
  endtask

  task automatic model_advance();
    for (int i = 0; i < NUM_CH; i++) begin
      int d;
      d = model_tgt[i] - model_cur[i];
      if (d > STEP)       model_cur[i] += STEP;
      else if (d < -STEP) model_cur[i] -= STEP;
      else                model_cur[i] = model_tgt[i];
    end
  endtask

  function automatic bit model_busy();
    bit b = 1'b0;
    for (int i = 0; i < NUM_CH; i++) if (model_cur[i] != model_tgt[i]) b = 1'b1;
    return b;
  endfunction

  task automatic push_model();
    for (int i = 0; i < NUM_CH; i++) exp_q.push_back(model_cur[i]);
  endtask

  // ---------------- drivers (called at a negedge) ----------------
  task automatic write_tbl(input int a, input int c, input int d);
    tbl_we = 1'b1; tbl_addr = 4'(a); tbl_ch = 3'(c); tbl_data = 16'(d);
    @(negedge clk);
    tbl_we = 1'b0;
    model_write(a, c, d);
  endtask

  task automatic strobe(input int g);
    gesture = 8'(g); gesture_valid = 1'b1;
    @(negedge clk);
    gesture_valid = 1'b0;
    model_gesture(g);
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int n = 0; n <= FRAME + 10; n++) begin
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Measures one full frame starting at frame_start and pops the expected
  // widths. Optionally strobes gesture g in the frame_start cycle itself.
  task automatic sb_frame(input bit strobe_now, input int g);
    int cnt[NUM_CH];
    int fs_cnt;
    bit ok;
    bit exp_busy;
    int exp_w;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_timeout: frame_start not seen within %0d cycles", FRAME + 10);
      for (int i = 0; i < NUM_CH; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    exp_busy = model_busy();
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL busy_at_wrap: got %b expected %b", busy, exp_busy);
    end
    fs_cnt = 0;
    for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (c == 0 && strobe_now) begin
        gesture = 8'(g);
        gesture_valid = 1'b1;
      end
      if (c == 1) gesture_valid = 1'b0;
      for (int i = 0; i < NUM_CH; i++) if (pwm_out[i] === 1'b1) cnt[i]++;
      if (frame_start === 1'b1) fs_cnt++;
      @(negedge clk);
    end
    if (strobe_now) model_gesture(g);
    checks++;
    if (fs_cnt != 1) begin
      errors++;
      $display("FAIL frame_start_count: got %0d pulses in frame expected 1", fs_cnt);
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_period: frame_start=%b after %0d cycles expected 1", frame_start, FRAME);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: ch%0d measured %0d with no expected width", i, cnt[i]);
      end else begin
        exp_w = exp_q.pop_front();
        if (cnt[i] !== exp_w) begin
          errors++;
          $display("FAIL width_ch%0d: got %0d cycles expected %0d", i, cnt[i], exp_w);
        end
      end
    end
  endtask

  task automatic measure_next();
    model_advance();
    push_model();
    sb_frame(1'b0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; gesture = '0; gesture_valid = 1'b0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_ch = '0; tbl_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (pwm_out !== 5'b00000) begin errors++; $display("FAIL reset_pwm: got %b expected 00000", pwm_out); end
    checks++;
    if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (pwm_out !== 5'b11111) begin errors++; $display("FAIL first_cycle_pwm: got %b expected 11111", pwm_out); end
    measure_next();
  endtask

  task automatic test_slew();
    int e3[NUM_CH] = '{1000, 1200, 1500, 1800, 2000};
    int f;
    repeat (100) @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) write_tbl(3, i, e3[i]);
    strobe(3);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL slew_busy_after_strobe: got %b expected 1", busy); end
    f = 0;
    do begin
      measure_next();
      f++;
    end while (model_busy() && f < 8);
    measure_next();
  endtask

  task automatic test_clamp();
    write_tbl(4, 0, 500);
    write_tbl(4, 3, 2600);
    write_tbl(4, 5, 1100);
    strobe(4);
    checks++;
    if (busy !== model_busy()) begin errors++; $display("FAIL clamp_busy_after_strobe: got %b expected %b", busy, model_busy()); end
    for (int f = 0; f < 8 && model_busy(); f++) measure_next();
    measure_next();
  endtask

  task automatic test_invalid_gesture();
    int codes[4] = '{0, 16, 19, 20};
    repeat (50) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      strobe(codes[k]);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL invalid_gesture_%0d_busy: got %b expected 0", codes[k], busy); end
    end
    measure_next();
  endtask

  task automatic test_gesture_on_frame_start();
    model_advance();
    push_model();
    sb_frame(1'b1, 3);
    measure_next();
    measure_next();
  endtask

  task automatic test_reset_mid_slew();
    repeat (700) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (pwm_out !== 5'b00000) begin errors++; $display("FAIL midreset_pwm: got %b expected 00000", pwm_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++;
    if (frame_start !== 1'b0) begin errors++; $display("FAIL midreset_frame_start: got %b expected 0", frame_start); end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (pwm_out !== 5'b11111) begin errors++; $display("FAIL midreset_first_pwm: got %b expected 11111", pwm_out); end
    strobe(3);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_table_cleared: busy=%b expected 0", busy); end
    measure_next();
  endtask

  task automatic test_same_cycle_write_lookup();
    repeat (20) @(negedge clk);
    tbl_we = 1'b1; tbl_addr = 4'd5; tbl_ch = 3'd0; tbl_data = 16'd1200;
    gesture = 8'd5; gesture_valid = 1'b1;
    @(negedge clk);
    tbl_we = 1'b0; gesture_valid = 1'b0;
    model_gesture(5);
    model_write(5, 0, 1200);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL same_cycle_old_data: busy=%b expected 0", busy); end
    strobe(5);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL same_cycle_new_data: busy=%b expected 1", busy); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_slew();
    test_clamp();
    test_invalid_gesture();
    test_gesture_on_frame_start();
    test_reset_mid_slew();
    test_same_cycle_write_lookup();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
